// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: issues sequential word fetches to a synchronous-read
// instruction memory, buffers returned words with their PCs in a DEPTH-entry queue,
// and hands them to decode over a valid/ready handshake. A redirect flushes all
// buffered and in-flight work and restarts fetch at a new word-aligned PC.
// Optional feature macro: IFU_PERF_COUNTERS_EN adds saturating perf_delivered and
// perf_redirects counters as extra output ports.
module instr_prefetch_unit #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              INSTR_WIDTH   = 32,
    parameter int unsigned              DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_WIDTH-1:0]   instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [31:0]              perf_delivered,
    output logic [31:0]              perf_redirects
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                     inflight_q, inflight_d;
    logic [ADDRESS_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]          count_q, count_d;
    logic [CntW-1:0]          occupancy;

    logic [INSTR_WIDTH-1:0]   instr_mem_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_mem_q    [DEPTH];

    logic push;
    logic pop;

    // Low address bits are always forced to zero on a redirect.
    logic unused_redirect_pc_lsb;
    assign unused_redirect_pc_lsb = ^redirect_pc[1:0];

    // The in-flight slot is counted as occupied so a returning word always has room.
    assign occupancy = count_q + CntW'(inflight_q);
    assign imem_req  = fetch_en & ~redirect & ~reset & (occupancy < CntW'(DEPTH));
    assign imem_addr = fetch_pc_q;

    // A redirect discards both the returning word and any pop in the same cycle.
    assign push = inflight_q & ~redirect;
    assign pop  = instr_valid & instr_ready & ~redirect;

    assign instr_valid = (count_q != '0);
    assign instr       = instr_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];

    // Next-state for fetch PC, in-flight tracking and queue bookkeeping.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            inflight_d = imem_req;
            if (imem_req) begin
                fetch_pc_d    = fetch_pc_q + ADDRESS_WIDTH'(4);
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage; contents are don't-care until count marks them valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] perf_delivered_q;
    logic [31:0] perf_redirects_q;

    // Saturating event counters for delivered instructions and redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_delivered_q <= '0;
            perf_redirects_q <= '0;
        end else begin
            if (instr_valid && instr_ready && (perf_delivered_q != '1)) begin
                perf_delivered_q <= perf_delivered_q + 32'd1;
            end
            if (redirect && (perf_redirects_q != '1)) begin
                perf_redirects_q <= perf_redirects_q + 32'd1;
            end
        end
    end

    assign perf_delivered = perf_delivered_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit: a cycle-by-cycle vector table on a
// 32-bit-address instance, a PC-wrap sequence on an 8-bit-address instance, and
// (with IFU_PERF_COUNTERS_EN) a performance counter sequence.
module tb_instr_prefetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: ADDRESS_WIDTH=32, DEPTH=4, RESET_PC=0.
    logic        reset, fetch_en, redirect, instr_ready;
    logic [31:0] redirect_pc;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc;

    // Wrap instance: ADDRESS_WIDTH=8.
    logic        s_reset, s_fetch_en, s_redirect, s_instr_ready;
    logic [7:0]  s_redirect_pc;
    logic        s_imem_req, s_instr_valid;
    logic [7:0]  s_imem_addr, s_instr_pc;
    logic [31:0] s_imem_rdata, s_instr;

`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] perf_delivered, perf_redirects;
    logic [31:0] s_perf_delivered, s_perf_redirects;
`endif

    instr_prefetch_unit #(
        .ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
`ifdef IFU_PERF_COUNTERS_EN
        , .perf_delivered(perf_delivered), .perf_redirects(perf_redirects)
`endif
    );

    instr_prefetch_unit #(
        .ADDRESS_WIDTH(8), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(8'h0)
    ) dut_s (
        .clk(clk), .reset(s_reset), .fetch_en(s_fetch_en), .redirect(s_redirect),
        .redirect_pc(s_redirect_pc), .imem_req(s_imem_req), .imem_addr(s_imem_addr),
        .imem_rdata(s_imem_rdata), .instr_valid(s_instr_valid),
        .instr_ready(s_instr_ready), .instr(s_instr), .instr_pc(s_instr_pc)
`ifdef IFU_PERF_COUNTERS_EN
        , .perf_delivered(s_perf_delivered), .perf_redirects(s_perf_redirects)
`endif
    );

    // Synchronous-read memory models: word i holds 0x1000_0000 + i.
    always @(posedge clk) imem_rdata <= 32'h1000_0000 + (imem_addr >> 2);
    always @(posedge clk) s_imem_rdata <= 32'h1000_0000 + {24'h0, s_imem_addr >> 2};

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, fe, rdr;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        cv;   // check instr_valid (and head when valid)
        logic        v;
        logic [31:0] ins;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(logic rst, logic fe, logic rdr, logic [31:0] rpc,
                                logic rdy, logic req, logic [31:0] addr, logic cv,
                                logic v, logic [31:0] ins, logic [31:0] pc);
        vec_t t;
        t.rst = rst; t.fe = fe; t.rdr = rdr; t.rpc = rpc; t.rdy = rdy;
        t.req = req; t.addr = addr; t.cv = cv; t.v = v; t.ins = ins; t.pc = pc;
        return t;
    endfunction

    function automatic logic [31:0] w(int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    vec_t tbl[$];
    logic [7:0] exp_pc [4];

    initial begin
        reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0;
        instr_ready = 1'b0;
        s_reset = 1'b1; s_fetch_en = 1'b0; s_redirect = 1'b0; s_redirect_pc = '0;
        s_instr_ready = 1'b0;

        //               rst fe rdr rpc      rdy req addr    cv v  instr      pc
        // Reset and stream
        tbl.push_back(mk(1, 1, 0, 0,       0,  0, 0,       0, 0, 0,        0));
        tbl.push_back(mk(1, 1, 0, 0,       0,  0, 0,       0, 0, 0,        0));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h0,     1, 0, 0,        0));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h4,     1, 0, 0,        0));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h8,     1, 1, w(0),     'h0));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'hC,     1, 1, w(1),     'h4));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h10,    1, 1, w(2),     'h8));
        // Backpressure: ready low for 10 cycles
        tbl.push_back(mk(1, 1, 0, 0,       0,  0, 0,       0, 0, 0,        0));
        tbl.push_back(mk(0, 1, 0, 0,       0,  1, 'h0,     1, 0, 0,        0));
        tbl.push_back(mk(0, 1, 0, 0,       0,  1, 'h4,     1, 0, 0,        0));
        tbl.push_back(mk(0, 1, 0, 0,       0,  1, 'h8,     1, 1, w(0),     'h0));
        tbl.push_back(mk(0, 1, 0, 0,       0,  1, 'hC,     1, 1, w(0),     'h0));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(0, 1, 0, 0,   0,  0, 'h10,    1, 1, w(0),     'h0));
        // Release: 0x0..0x10 in order
        tbl.push_back(mk(0, 1, 0, 0,       1,  0, 'h10,    1, 1, w(0),     'h0));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h10,    1, 1, w(1),     'h4));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h14,    1, 1, w(2),     'h8));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h18,    1, 1, w(3),     'hC));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h1C,    1, 1, w(4),     'h10));
        // Build 3 queued + 1 in flight, then redirect to 0x42
        tbl.push_back(mk(0, 1, 0, 0,       0,  1, 'h20,    1, 1, w(5),     'h14));
        tbl.push_back(mk(0, 1, 1, 'h42,    0,  0, 'h24,    1, 1, w(5),     'h14));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h40,    1, 0, 0,        0));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h44,    1, 0, 0,        0));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h48,    1, 1, w('h10),  'h40));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h4C,    1, 1, w('h11),  'h44));
        // Redirect coinciding with a pop
        tbl.push_back(mk(0, 1, 1, 'h80,    1,  0, 'h50,    1, 1, w('h12),  'h48));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h80,    1, 0, 0,        0));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h84,    1, 0, 0,        0));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h88,    1, 1, w('h20),  'h80));
        // Reset coinciding with redirect
        tbl.push_back(mk(1, 1, 1, 'h100,   1,  0, 0,       0, 0, 0,        0));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h0,     1, 0, 0,        0));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h4,     1, 0, 0,        0));
        tbl.push_back(mk(0, 1, 0, 0,       1,  1, 'h8,     1, 1, w(0),     'h0));
        // fetch_en low: in-flight word still lands
        tbl.push_back(mk(0, 0, 0, 0,       0,  0, 'hC,     1, 1, w(1),     'h4));
        tbl.push_back(mk(0, 0, 0, 0,       0,  0, 'hC,     1, 1, w(1),     'h4));
        tbl.push_back(mk(0, 0, 0, 0,       1,  0, 'hC,     1, 1, w(1),     'h4));
        tbl.push_back(mk(0, 0, 0, 0,       1,  0, 'hC,     1, 1, w(2),     'h8));
        tbl.push_back(mk(0, 0, 0, 0,       1,  0, 'hC,     1, 0, 0,        0));

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            reset = tbl[i].rst; fetch_en = tbl[i].fe; redirect = tbl[i].rdr;
            redirect_pc = tbl[i].rpc; instr_ready = tbl[i].rdy;
            @(negedge clk);
            check("imem_req", i, {31'b0, imem_req}, {31'b0, tbl[i].req});
            if (!tbl[i].rst) check("imem_addr", i, imem_addr, tbl[i].addr);
            if (tbl[i].cv) begin
                check("instr_valid", i, {31'b0, instr_valid}, {31'b0, tbl[i].v});
                if (tbl[i].v) begin
                    check("instr", i, instr, tbl[i].ins);
                    check("instr_pc", i, instr_pc, tbl[i].pc);
                end
            end
            @(posedge clk); #1;
        end

        // PC wrap on the 8-bit instance
        exp_pc[0] = 8'hF8; exp_pc[1] = 8'hFC; exp_pc[2] = 8'h00; exp_pc[3] = 8'h04;
        s_reset = 1'b0; s_redirect = 1'b1; s_redirect_pc = 8'hF8;
        s_fetch_en = 1'b1; s_instr_ready = 1'b1;
        @(posedge clk); #1;
        s_redirect = 1'b0;
        begin
            int k;
            k = 0;
            for (int c = 0; c < 20 && k < 4; c++) begin
                @(negedge clk);
                if (s_instr_valid) begin
                    check("wrap_pc", k, {24'h0, s_instr_pc}, {24'h0, exp_pc[k]});
                    check("wrap_instr", k, s_instr,
                          32'h1000_0000 + {24'h0, exp_pc[k] >> 2});
                    k++;
                end
                @(posedge clk); #1;
            end
            if (k < 4) check("wrap_timeout", k, 32'(k), 32'd4);
        end

`ifdef IFU_PERF_COUNTERS_EN
        // Performance counters: clear, 2 redirects, 5 handshakes
        reset = 1'b1; redirect = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("perf_delivered_rst", 0, perf_delivered, 32'd0);
        check("perf_redirects_rst", 0, perf_redirects, 32'd0);
        @(posedge clk); #1;
        for (int r = 0; r < 2; r++) begin
            redirect = 1'b1; redirect_pc = 32'h200;
            @(posedge clk); #1;
            redirect = 1'b0;
            @(posedge clk); #1;
        end
        fetch_en = 1'b1; instr_ready = 1'b1;
        begin
            int hs;
            logic seen;
            hs = 0;
            for (int c = 0; c < 30 && hs < 5; c++) begin
                @(negedge clk);
                seen = instr_valid & instr_ready;
                @(posedge clk); #1;
                if (seen) hs++;
                if (hs == 5) instr_ready = 1'b0;
            end
            if (hs < 5) check("perf_hs_timeout", hs, 32'(hs), 32'd5);
        end
        @(negedge clk);
        check("perf_delivered", 1, perf_delivered, 32'd5);
        check("perf_redirects", 1, perf_redirects, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
- Parametrised successor to the single-cycle instruction fetch unit.
- Decouples fetch from decode:
  - issues sequential word fetches to a synchronous-read instruction memory;
  - buffers returned instructions with their PCs in a DEPTH-entry queue;
  - hands them to decode over a valid/ready handshake.
- A redirect input (branch/jump from execute) flushes all buffered and in-flight work and restarts fetch at a new PC.
- Sits between the instruction memory and the decode/register-file stage of the pipelined core.

Parameters:
- ADDRESS_WIDTH, 32, width of PC and instruction-memory address.
- INSTR_WIDTH, 32, width of one instruction word.
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 0, fetch PC after reset; word aligned.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_en  input  1  permits new memory requests when high.
- redirect  input  1  flush and restart fetch this edge.
- redirect_pc  input  ADDRESS_WIDTH  new fetch PC; bits [1:0] ignored (forced to 0).
- imem_req  output  1  memory read request this cycle.
- imem_addr  output  ADDRESS_WIDTH  byte address of the request (= fetch_pc).
- imem_rdata  input  INSTR_WIDTH  read data; valid exactly one cycle after imem_req.
- instr_valid  output  1  queue head valid.
- instr_ready  input  1  decode accepts head this cycle.
- instr  output  INSTR_WIDTH  head instruction.
- instr_pc  output  ADDRESS_WIDTH  PC of head instruction.

Behaviour:
- State:
  - fetch_pc;
  - inflight flag and inflight_pc;
  - queue storage with rd_ptr, wr_ptr and count (0..DEPTH).
- Reset (sync, wins over everything):
  - fetch_pc=RESET_PC, inflight=0, count=0, pointers=0;
  - instr_valid=0, imem_req=0;
  - instr and instr_pc are don't-care while instr_valid=0.
- Request (combinational):
  - imem_req = fetch_en & ~redirect & ~reset & (count + inflight < DEPTH).
  - The in-flight slot is reserved, so the queue can never overflow.
- On edge with imem_req=1: fetch_pc <= fetch_pc+4 (wraps modulo 2^ADDRESS_WIDTH), inflight <= 1, inflight_pc <= fetch_pc.
- On edge with imem_req=0: inflight <= 0.
- Push: on an edge where inflight=1 and redirect=0, write {imem_rdata, inflight_pc} at wr_ptr.
- Pop: on an edge where instr_valid & instr_ready, advance rd_ptr.
- Push and pop on the same edge: count unchanged. Pointers wrap modulo DEPTH.
- Output: instr_valid = (count != 0); instr/instr_pc read the head entry directly (no bypass).
- Latency:
  - imem_req at cycle n -> data pushed at edge ending cycle n+1 -> instr_valid at cycle n+2.
  - Sustained throughput is 1 instruction/cycle when instr_ready is held high.
- Redirect (edge with redirect=1 and reset=0):
  - count=0, pointers=0, inflight=0 (returning data dropped);
  - fetch_pc <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
  - imem_req forced low that cycle;
  - a pop in the same cycle is ignored (queue flushed regardless).
  - First redirected instruction is valid 2 cycles after the first post-redirect request.
- Full (count+inflight == DEPTH): no request; fetch_pc holds; resumes the cycle a pop frees a slot.
- fetch_en low: no new requests; an already in-flight response is still pushed.
- instr/instr_pc must be stable while instr_valid=1 and instr_ready=0.

Optional Feature:
- Macro IFU_PERF_COUNTERS_EN.
- When defined, adds two output ports, each 32 bits, saturating at 0xFFFF_FFFF and cleared by reset:
  - perf_delivered: increments on each instr_valid & instr_ready edge;
  - perf_redirects: increments on each redirect edge.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset and stream:
  - memory word i = 0x1000_0000+i; RESET_PC=0; fetch_en=1; instr_ready=1 after reset deasserts;
  - -> instr_valid first high 2 cycles after first imem_req;
  - -> instr/instr_pc = 0x1000_0000/0x0, 0x1000_0001/0x4, 0x1000_0002/0x8 on consecutive cycles.
- Backpressure, DEPTH=4:
  - instr_ready=0 for 10 cycles -> count reaches 4, imem_req low, fetch_pc = 0x10, head stays 0x1000_0000/0x0;
  - instr_ready=1 -> PCs 0x0,0x4,0x8,0xC,0x10 delivered in order with no gap or duplicate.
- Redirect mid-stream:
  - with 3 entries queued and 1 in flight, pulse redirect with redirect_pc=0x42 -> instr_valid=0 next cycle, in-flight data dropped;
  - -> next delivered is 0x1000_0010 at PC 0x40, then PC 0x44.
- Simultaneous events:
  - redirect coinciding with a pop -> queue emptied, no stale instruction delivered;
  - reset coinciding with redirect -> fetch restarts at RESET_PC.
- PC wrap: ADDRESS_WIDTH=8, redirect_pc=0xF8 -> delivered PCs 0xF8, 0xFC, 0x00, 0x04.
- Performance counters, with IFU_PERF_COUNTERS_EN:
  - 5 handshakes and 2 redirects -> perf_delivered=5, perf_redirects=2;
  - reset -> both 0.
